// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared types and constants for the prio_enc_arb slice.
//   state_e      - arbiter FSM states (EMPTY: no result held, FULL: result held)
//   ptr_reset_val - reset value of the round-robin pointer as a function of N
// Optional feature macro used by this slice: PRIO_ENC_RR_EN.
package prio_enc_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // The pointer starts at the top index so the first round-robin scan
  // matches fixed priority.
  function automatic int ptr_reset_val(int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/prio_enc_arb_if.sv
// prio_enc_arb_if: request/result bundle between sources, arbiter and consumer.
//   req[N]        request vector, level-sensitive
//   en            load enable
//   rr_mode       round-robin select (only with PRIO_ENC_RR_EN)
//   out_ready     consumer accepts the held result
//   out_valid     held result valid
//   out_idx[W]    winner index
//   out_grant[N]  one-hot winner grant
// Handshake: a result transfers on every rising edge where out_valid and
// out_ready are both high; out_valid never drops without such a transfer
// (except on reset), and out_ready may be high while out_valid is low.
// modport slave is the arbiter side, modport master the environment side.
interface prio_enc_arb_if #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) ();

  logic [N-1:0] req;
  logic         en;
`ifdef PRIO_ENC_RR_EN
  logic         rr_mode;
`endif
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_grant;

`ifdef PRIO_ENC_RR_EN
  modport slave  (input  req, en, rr_mode, out_ready,
                  output out_valid, out_idx, out_grant);
  modport master (output req, en, rr_mode, out_ready,
                  input  out_valid, out_idx, out_grant);
`else
  modport slave  (input  req, en, out_ready,
                  output out_valid, out_idx, out_grant);
  modport master (output req, en, out_ready,
                  input  out_valid, out_idx, out_grant);
`endif

endinterface

// File: rtl/prio_enc_scan.sv
// prio_enc_scan: combinational downward scan with wrap.
//   req[N]   request vector
//   start[W] first index examined; scan order start, start-1, ..., 0, N-1, ..., start+1
//   found    at least one request set
//   idx[W]   first set index in scan order (0 when nothing found)
module prio_enc_scan #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) - k;
      if (pos < 0) pos = pos + N;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = W'(pos);
      end
    end
  end

endmodule

// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered priority encoder / arbiter with valid/ready output.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        prio_enc_arb_if.slave (req, en, [rr_mode], out_ready ->
//              out_valid, out_idx, out_grant)
//   dbg_state  current FSM state
// Fixed priority picks the highest set index. With PRIO_ENC_RR_EN defined,
// rr_mode selects a rotating scan starting below the last accepted winner.
module prio_enc_arb
  import prio_enc_pkg::*;
#(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  prio_enc_arb_if.slave   bus,
  output state_e          dbg_state
);

  localparam logic [W-1:0] TOP_IDX = W'(N - 1);

  state_e       state_q, state_d;
  logic [W-1:0] idx_q;
  logic [N-1:0] grant_q;
  logic         accept;
  logic         load;
  logic         found;
  logic [W-1:0] start;
  logic [W-1:0] scan_idx;

  assign accept = (state_q == FULL) && bus.out_ready;
  // A held result blocks loading unless it is being accepted this cycle.
  assign load   = bus.en && found && ((state_q == EMPTY) || bus.out_ready);

`ifdef PRIO_ENC_RR_EN
  localparam logic [W-1:0] PTR_RST = W'(ptr_reset_val(N));

  logic [W-1:0] ptr_q, ptr_d;

  // The pointer advances past the winner being accepted now, and that
  // advanced value already steers a same-cycle reload.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && bus.rr_mode) begin
      ptr_d = (idx_q == '0) ? TOP_IDX : idx_q - W'(1);
    end
  end

  assign start = bus.rr_mode ? ptr_d : TOP_IDX;

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= PTR_RST;
    else        ptr_q <= ptr_d;
  end
`else
  assign start = TOP_IDX;
`endif

  prio_enc_scan #(.N(N)) u_scan (
    .req   (bus.req),
    .start (start),
    .found (found),
    .idx   (scan_idx)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL: begin
        if (load)               state_d = FULL;
        else if (bus.out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // out_idx keeps its last value when the result is consumed; only the grant
  // is cleared so that it reads zero whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      grant_q <= '0;
    end else if (load) begin
      idx_q   <= scan_idx;
      grant_q <= {{(N-1){1'b0}}, 1'b1} << scan_idx;
    end else if (accept) begin
      grant_q <= '0;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_idx   = idx_q;
  assign bus.out_grant = grant_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// tb_prio_enc_arb: bench for prio_enc_arb with N=16 and N=5 instances.
// Build with or without PRIO_ENC_RR_EN; round-robin stimulus is used only
// when the macro is defined.
module tb_prio_enc_arb;
  import prio_enc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic rr;

  prio_enc_arb_if #(.N(16)) bus16 ();
  prio_enc_arb_if #(.N(5))  bus5 ();
  state_e dbg16, dbg5;

  prio_enc_arb #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16), .dbg_state(dbg16));
  prio_enc_arb #(.N(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5),  .dbg_state(dbg5));

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int m_valid[2];
  int m_idx[2];
  int m_ptr[2];
  int nn[2] = '{16, 5};
  logic [3:0] exp_q16[$];
  logic [3:0] exp_q5[$];

  // First set request scanning downward from start with wrap; -1 if none.
  function automatic int pick(logic [15:0] r, int n, int start);
    for (int k = 0; k < n; k++) begin
      int p;
      p = (start - k + n) % n;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_step(int d, logic [15:0] r, logic e, logic rdy, logic rr_e, logic rst_v);
    int n, w;
    bit acc;
    n = nn[d];
    if (!rst_v) begin
      m_valid[d] = 0;
      m_idx[d]   = 0;
      m_ptr[d]   = n - 1;
      if (d == 0) exp_q16.delete(); else exp_q5.delete();
    end else begin
      acc = (m_valid[d] != 0) && rdy;
      if (acc && rr_e) m_ptr[d] = (m_idx[d] == 0) ? n - 1 : m_idx[d] - 1;
      if (e && r != 0 && (m_valid[d] == 0 || rdy)) begin
        w = pick(r, n, rr_e ? m_ptr[d] : n - 1);
        m_valid[d] = 1;
        m_idx[d]   = w;
        if (d == 0) exp_q16.push_back(4'(w)); else exp_q5.push_back(4'(w));
      end else if (acc) begin
        m_valid[d] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, bus16.req, bus16.en, bus16.out_ready, rr, rst_n);
    model_step(1, {11'b0, bus5.req}, bus5.en, bus5.out_ready, rr, rst_n);
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(int d, string tag, logic valid, logic [3:0] idx,
                           logic [15:0] grant, logic rdy, state_e st);
    logic [3:0] e;
    chk({tag, "_valid"}, 32'(valid), 32'(m_valid[d]));
    chk({tag, "_state"}, 32'(st == FULL), 32'(m_valid[d]));
    if (m_valid[d] != 0) begin
      chk({tag, "_idx_held"}, 32'(idx), 32'(m_idx[d]));
      chk({tag, "_grant"}, 32'(grant), 32'(1) << m_idx[d]);
      if (valid && rdy) begin
        checks++;
        if ((d == 0 && exp_q16.size() == 0) || (d == 1 && exp_q5.size() == 0)) begin
          failures++;
          $display("FAIL %s_accept: got transfer idx %0d expected no result pending", tag, idx);
        end else begin
          e = (d == 0) ? exp_q16.pop_front() : exp_q5.pop_front();
          if (idx !== e) begin
            failures++;
            $display("FAIL %s_accept: got idx %0d expected %0d at %0t", tag, idx, e, $time);
          end
        end
      end
    end else begin
      chk({tag, "_grant_zero"}, 32'(grant), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, "n16", bus16.out_valid, bus16.out_idx, bus16.out_grant, bus16.out_ready, dbg16);
    check_dut(1, "n5", bus5.out_valid, {1'b0, bus5.out_idx}, {11'b0, bus5.out_grant},
              bus5.out_ready, dbg5);
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(logic [15:0] r16, logic [4:0] r5, logic e, logic rdy, logic rr_v);
    bus16.req = r16;
    bus5.req  = r5;
    bus16.en  = e;
    bus5.en   = e;
    bus16.out_ready = rdy;
    bus5.out_ready  = rdy;
`ifdef PRIO_ENC_RR_EN
    bus16.rr_mode = rr_v;
    bus5.rr_mode  = rr_v;
    rr = rr_v;
`else
    rr = 1'b0;
    if (rr_v) rr = 1'b0;
`endif
  endtask

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    logic [15:0] r16;
    rst_n = 1'b0;
    set_in(16'hFFFF, 5'h1F, 1'b1, 1'b1, 1'b0);
    cycles(2);
    chk("rst_valid", 32'(bus16.out_valid), 32'd0);
    chk("rst_grant", 32'(bus16.out_grant), 32'd0);
    chk("rst_idx", 32'(bus16.out_idx), 32'd0);
    rst_n = 1'b1;
    cycles(1);
    chk("first_idx", 32'(bus16.out_idx), 32'd15);

    // fixed priority, continuous results
    set_in(16'h0025, 5'b00101, 1'b1, 1'b1, 1'b0);
    cycles(6);
    chk("fixed_idx", 32'(bus16.out_idx), 32'd5);
    chk("fixed_grant", 32'(bus16.out_grant), 32'h0020);

    // drain, then backpressure
    set_in(16'h0000, 5'b00000, 1'b0, 1'b1, 1'b0);
    cycles(2);
    set_in(16'h0100, 5'b00010, 1'b1, 1'b0, 1'b0);
    cycles(1);
    set_in(16'h8000, 5'b10000, 1'b1, 1'b0, 1'b0);
    cycles(5);
    chk("bp_hold_idx", 32'(bus16.out_idx), 32'd8);
    set_in(16'h8000, 5'b10000, 1'b1, 1'b1, 1'b0);
    cycles(1);
    chk("bp_b2b_idx", 32'(bus16.out_idx), 32'd15);
    chk("bp_b2b_valid", 32'(bus16.out_valid), 32'd1);

    // en low with all requests, then en high with none
    set_in(16'hFFFF, 5'h1F, 1'b0, 1'b1, 1'b0);
    cycles(4);
    chk("en_low_valid", 32'(bus16.out_valid), 32'd0);
    set_in(16'h0000, 5'h00, 1'b1, 1'b1, 1'b0);
    cycles(3);
    chk("zero_req_valid", 32'(bus16.out_valid), 32'd0);

`ifdef PRIO_ENC_RR_EN
    // round-robin rotation: 15,10,5,0,15 on N=16 and 4,0,4 on N=5
    set_in(16'h8421, 5'b10001, 1'b1, 1'b1, 1'b1);
    cycles(5);
    chk("rr_wrap_idx", 32'(bus16.out_idx), 32'd15);
    cycles(3);
    set_in(16'h0000, 5'h00, 1'b0, 1'b1, 1'b1);
    cycles(2);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r16 = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 9) == 0) r16 = '0;
      set_in(r16, 5'($urandom_range(0, 31)), ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      cycles(1);
    end

    // reset while holding a result
    set_in(16'h0100, 5'b00100, 1'b1, 1'b0, 1'b0);
    t = 0;
    while (!bus16.out_valid && t < 10) begin
      cycles(1);
      t++;
    end
    checks++;
    if (t == 10) begin
      failures++;
      $display("FAIL wait_valid: got no out_valid within 10 cycles expected a load");
    end
    rst_n = 1'b0;
    cycles(1);
    chk("rst_full_valid", 32'(bus16.out_valid), 32'd0);
    chk("rst_full_valid_n5", 32'(bus5.out_valid), 32'd0);
    rst_n = 1'b1;

    // drain and confirm every expected result was delivered
    set_in(16'h0000, 5'h00, 1'b0, 1'b1, 1'b0);
    cycles(3);
    chk("q16_empty", 32'(exp_q16.size()), 32'd0);
    chk("q5_empty", 32'(exp_q5.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prio_enc_arb.md
# prio_enc_arb

Parametrised, registered priority encoder and arbiter for N request lines. It samples a request vector, selects one winner, and holds the winner's binary index and one-hot grant behind a valid/ready handshake until the consumer accepts it. Winner selection is fixed highest-index-first, with an optional round-robin mode. It sits between request sources (interrupt/event lines, bank requests) and a single downstream consumer.

## Interface
- N, default 16: number of request lines; must be at least 2; need not be a power of two.
- W, default $clog2(N): index width; derived, not overridden.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low.
- req  input  N  request vector, level-sensitive; bit i is request i.
- en  input  1  load enable; when low, no new winner is captured.
- rr_mode  input  1  selects round-robin when high (only present with PRIO_ENC_RR_EN).
- out_ready  input  1  consumer accepts the held result.
- out_valid  output  1  the held result is valid.
- out_idx  output  W  binary index of the winner.
- out_grant  output  N  one-hot grant, equal to 1 << out_idx while out_valid is high, otherwise 0.

## Operation
- The block has two states: EMPTY and FULL.
- A load occurs in EMPTY when en is high and req is non-zero.
- A load also occurs in FULL when out_ready is high, en is high and req is non-zero. This gives back-to-back loads.
- On a load:
  - The winner is registered into out_idx and out_grant.
  - out_valid is 1 and the state is FULL at the next edge.
- In FULL, if out_ready is high and no load condition holds, the next state is EMPTY with out_valid = 0.
- In FULL with out_ready low, all outputs hold and changes on req are ignored.
- Fixed-priority mode: the winner is the highest set index, N-1 down to 0.
- Round-robin mode:
  - The scan runs downward from pointer ptr with wrap: ptr, ptr-1, …, 0, N-1, …, ptr+1.
  - On each accepted transfer (out_valid and out_ready), ptr becomes out_idx-1. If out_idx is 0, ptr becomes N-1.
  - ptr never takes a value of N or above.
- A req value of zero never produces a load. out_idx keeps its last value while out_valid is low; consumers must not use it.
- en low blocks new loads only. A held result still completes its handshake.
- A change of rr_mode takes effect at the next load. ptr keeps updating only while round-robin mode is selected.

## Timing
- Reset values, applied at the edge where rst_n is low: state EMPTY, out_valid 0, out_idx 0, out_grant 0, ptr N-1.
- Reset during FULL discards the held result at that edge, with no handshake.
- Latency: req sampled at edge k appears as out_valid/out_idx after edge k.
- Throughput: one result per cycle while out_ready stays high and requests persist.
- There is no combinational path from req or en to any output.
- out_ready may be high while out_valid is low; this has no effect.
- Simultaneous accept and new request in one cycle produce a load, not a pass through EMPTY. ptr is updated from the accepted index before the scan for the new load starts.

## Configuration
- PRIO_ENC_RR_EN defined:
  - The rr_mode port, the ptr register and the rotated scan are compiled in.
- PRIO_ENC_RR_EN undefined:
  - The rr_mode port and ptr register are absent.
  - Fixed priority only.
  - Behaviour is identical to the defined build with rr_mode tied to 0.

## Structure
- Package prio_enc_pkg holds:
  - the state enum typedef (EMPTY, FULL);
  - the reset constant for ptr, expressed as a function of N.
- Sub-module prio_enc_scan:
  - Combinational, parametrised by N.
  - Inputs: req and start index. Outputs: found and idx.
  - The scan runs downward with wrap from the start index.
  - Fixed mode drives start = N-1. The top level holds the FSM, the output registers and ptr.

## Test plan
- Reset: hold rst_n low for 2 cycles with req = 16'hFFFF. Expect out_valid 0, out_grant 0 and no load. After release with en = 1, expect out_idx 15 one cycle later.
- Fixed priority: req = 16'h0025 with out_ready = 1. Expect out_idx 5 and out_grant 16'h0020 for every result while req holds.
- Backpressure: load with req = 16'h0100, hold out_ready low for 5 cycles and change req to 16'h8000. Expect out_idx to stay 8. Raise out_ready and expect out_idx 15 on the next cycle, back-to-back.
- Round-robin (macro defined, rr_mode 1): req = 16'h8421 constant, out_ready = 1. Expect out_idx sequence 15, 10, 5, 0, 15.
- Non-power-of-two, N = 5, rr_mode 1: req = 5'b10001. Expect out_idx sequence 4, 0, 4. ptr must stay ≤ 4.
- en low and zero req:
  - en = 0 with req = 16'hFFFF: out_valid stays 0.
  - en = 1 with req = 0: out_valid stays 0.
  - Reset while FULL: out_valid is 0 at the next edge.
